// File: rtl/lsu_pkg.sv
// Shared types, lane constants and the byte-enable helper for the memory-stage load/store unit.
package lsu_pkg;

   localparam int unsigned LSU_DATA_WIDTH = 32;
   localparam int unsigned BYTE_LANES     = LSU_DATA_WIDTH / 8;
   localparam int unsigned LANE_SEL_W     = $clog2(BYTE_LANES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } lsu_state_t;

   function automatic logic [BYTE_LANES-1:0] lane_be(input logic                  byte_op,
                                                     input logic [LANE_SEL_W-1:0] lane);
      logic [BYTE_LANES-1:0] be;
      if (byte_op) begin
         be = {{(BYTE_LANES-1){1'b0}}, 1'b1} << lane;
      end else begin
         be = {BYTE_LANES{1'b1}};
      end
      return be;
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane logic: store-data replication, byte enables and load-lane
// extraction with zero extension.
module byte_lane_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = LSU_DATA_WIDTH
) (
   input  logic                  i_byte_op,
   input  logic [LANE_SEL_W-1:0] i_wr_lane,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [BYTE_LANES-1:0] o_be,
   output logic [DATA_WIDTH-1:0] o_wdata,
   input  logic                  i_rd_byte_op,
   input  logic [LANE_SEL_W-1:0] i_rd_lane,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [7:0] w_rd_byte;

   assign o_be    = lane_be(i_byte_op, i_wr_lane);
   assign o_wdata = i_byte_op ? {(DATA_WIDTH/8){i_wdata[7:0]}} : i_wdata;

   assign w_rd_byte = i_rdata[{i_rd_lane, 3'b000} +: 8];
   assign o_rdata   = i_rd_byte_op ? {{(DATA_WIDTH-8){1'b0}}, w_rd_byte} : i_rdata;

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store sequencer driving a req/gnt/rvalid data-memory port.
// Optional misaligned-word trap enabled by defining LSU_ALIGN_CHECK_EN.
module memory_access_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = LSU_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_ni,
   input  logic [DATA_WIDTH-1:0]   alu_result_m_i,
   input  logic [DATA_WIDTH-1:0]   write_data_m_i,
   input  logic                    memory_m_i,
   input  logic                    mem_write_m_i,
   input  logic                    byte_op_m_i,
   output logic                    stall_m_o,
   output logic                    dmem_req_o,
   output logic                    dmem_we_o,
   output logic [DATA_WIDTH-1:0]   dmem_addr_o,
   output logic [DATA_WIDTH/8-1:0] dmem_be_o,
   output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
   input  logic                    dmem_gnt_i,
   input  logic                    dmem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
   output logic [DATA_WIDTH-1:0]   read_data_m_o,
   output logic                    misalign_o
);

   lsu_state_t r_state, w_state_d;

   logic                    r_req, w_req_d;
   logic                    r_we, w_we_d;
   logic [DATA_WIDTH-1:0]   r_addr, w_addr_d;
   logic [DATA_WIDTH/8-1:0] r_be, w_be_d;
   logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
   logic                    r_byte_op, w_byte_op_d;
   logic [LANE_SEL_W-1:0]   r_lane, w_lane_d;
   logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_d;
   logic                    r_misalign, w_misalign_d;

   logic [BYTE_LANES-1:0]   w_be;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic [DATA_WIDTH-1:0]   w_ld_data;
   logic                    w_misaligned;

   byte_lane_unit #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_byte_lane_unit (
      .i_byte_op    (byte_op_m_i),
      .i_wr_lane    (alu_result_m_i[LANE_SEL_W-1:0]),
      .i_wdata      (write_data_m_i),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .i_rd_byte_op (r_byte_op),
      .i_rd_lane    (r_lane),
      .i_rdata      (dmem_rdata_i),
      .o_rdata      (w_ld_data)
   );

`ifdef LSU_ALIGN_CHECK_EN
   assign w_misaligned = !byte_op_m_i && (alu_result_m_i[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   // Stall drops in DONE so the pipeline advances on the DONE -> IDLE edge.
   assign stall_m_o = memory_m_i && (r_state != DONE);

   always_comb begin
      w_state_d    = r_state;
      w_req_d      = r_req;
      w_we_d       = r_we;
      w_addr_d     = r_addr;
      w_be_d       = r_be;
      w_wdata_d    = r_wdata;
      w_byte_op_d  = r_byte_op;
      w_lane_d     = r_lane;
      w_rdata_d    = r_rdata;
      w_misalign_d = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (memory_m_i) begin
               if (w_misaligned) begin
                  w_state_d    = DONE;
                  w_misalign_d = 1'b1;
                  if (!mem_write_m_i) begin
                     w_rdata_d = '0;
                  end
               end else begin
                  w_state_d   = REQ;
                  w_req_d     = 1'b1;
                  w_we_d      = mem_write_m_i;
                  w_addr_d    = {alu_result_m_i[DATA_WIDTH-1:2], 2'b00};
                  w_be_d      = w_be;
                  w_wdata_d   = w_wdata;
                  w_byte_op_d = byte_op_m_i;
                  w_lane_d    = alu_result_m_i[LANE_SEL_W-1:0];
               end
            end
         end
         REQ: begin
            if (dmem_gnt_i) begin
               w_req_d   = 1'b0;
               w_state_d = r_we ? DONE : WAIT_R;
            end
         end
         WAIT_R: begin
            if (dmem_rvalid_i) begin
               w_rdata_d = w_ld_data;
               w_state_d = DONE;
            end
         end
         DONE: begin
            w_state_d = IDLE;
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_byte_op  <= 1'b0;
         r_lane     <= '0;
         r_rdata    <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_req      <= w_req_d;
         r_we       <= w_we_d;
         r_addr     <= w_addr_d;
         r_be       <= w_be_d;
         r_wdata    <= w_wdata_d;
         r_byte_op  <= w_byte_op_d;
         r_lane     <= w_lane_d;
         r_rdata    <= w_rdata_d;
         r_misalign <= w_misalign_d;
      end
   end

   assign dmem_req_o    = r_req;
   assign dmem_we_o     = r_we;
   assign dmem_addr_o   = r_addr;
   assign dmem_be_o     = r_be;
   assign dmem_wdata_o  = r_wdata;
   assign read_data_m_o = r_rdata;
   assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit with hand-computed expectations.
module tb_memory_access_unit;

   logic        clk;
   logic        rst_ni;
   logic [31:0] alu_result_m_i;
   logic [31:0] write_data_m_i;
   logic        memory_m_i;
   logic        mem_write_m_i;
   logic        byte_op_m_i;
   logic        stall_m_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] read_data_m_o;
   logic        misalign_o;

   int n_checks;
   int n_errors;

   memory_access_unit #(
      .DATA_WIDTH (32)
   ) dut (
      .clk            (clk),
      .rst_ni         (rst_ni),
      .alu_result_m_i (alu_result_m_i),
      .write_data_m_i (write_data_m_i),
      .memory_m_i     (memory_m_i),
      .mem_write_m_i  (mem_write_m_i),
      .byte_op_m_i    (byte_op_m_i),
      .stall_m_o      (stall_m_o),
      .dmem_req_o     (dmem_req_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_be_o      (dmem_be_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_gnt_i     (dmem_gnt_i),
      .dmem_rvalid_i  (dmem_rvalid_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .read_data_m_o  (read_data_m_o),
      .misalign_o     (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one access starting at a negedge; grant after gnt_delay REQ cycles, rvalid one
   // cycle after grant. Returns at the DONE-cycle negedge (+1) with memory_m_i still high.
   task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input logic byte_op, input int gnt_delay,
                            input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            output int stall_cycles, output logic saw_req);
      int   req_cycles;
      int   cyc;
      logic granted;
      alu_result_m_i = addr;
      write_data_m_i = wdata;
      mem_write_m_i  = we;
      byte_op_m_i    = byte_op;
      memory_m_i     = 1'b1;
      dmem_gnt_i     = 1'b0;
      dmem_rvalid_i  = 1'b0;
      #1;
      if (!stall_m_o) begin
         @(negedge clk);
         #1;
      end
      stall_cycles = 0;
      req_cycles   = 0;
      cyc          = 0;
      granted      = 1'b0;
      saw_req      = 1'b0;
      while (stall_m_o && cyc < 50) begin
         stall_cycles++;
         dmem_rvalid_i = 1'b0;
         dmem_gnt_i    = 1'b0;
         if (dmem_req_o) begin
            saw_req = 1'b1;
            check_eq("req_addr", dmem_addr_o, exp_addr);
            check_eq("req_be", {28'd0, dmem_be_o}, {28'd0, exp_be});
            check_eq("req_wdata", dmem_wdata_o, exp_wdata);
            check_eq("req_we", {31'd0, dmem_we_o}, {31'd0, we});
            if (req_cycles == gnt_delay) begin
               dmem_gnt_i = 1'b1;
               granted    = 1'b1;
            end
            req_cycles++;
         end else if (granted && !we) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
            granted       = 1'b0;
         end
         @(negedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 50) check_eq("access_timeout", 32'(cyc), 32'd0);
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      check_eq("done_req", {31'd0, dmem_req_o}, 32'd0);
   endtask

   task automatic idle_cycle();
      memory_m_i = 1'b0;
      @(negedge clk);
      #1;
   endtask

   int   sc;
   logic sr;

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst_ni         = 1'b0;
      alu_result_m_i = '0;
      write_data_m_i = '0;
      memory_m_i     = 1'b0;
      mem_write_m_i  = 1'b0;
      byte_op_m_i    = 1'b0;
      dmem_gnt_i     = 1'b0;
      dmem_rvalid_i  = 1'b0;
      dmem_rdata_i   = '0;
      @(negedge clk);
      check_eq("rst_req", {31'd0, dmem_req_o}, 32'd0);
      check_eq("rst_addr", dmem_addr_o, 32'd0);
      check_eq("rst_rdata", read_data_m_o, 32'd0);
      check_eq("rst_stall", {31'd0, stall_m_o}, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk);
      #1;

      // Word load, zero-wait
      do_access(32'h0000_0104, 32'h0, 1'b0, 1'b0, 0, 32'hDEAD_BEEF,
                32'h0000_0104, 4'hF, 32'h0, sc, sr);
      check_eq("wl_stall", 32'(sc), 32'd3);
      check_eq("wl_rdata", read_data_m_o, 32'hDEAD_BEEF);
      check_eq("wl_misalign", {31'd0, misalign_o}, 32'd0);
      idle_cycle();

      // Byte store, zero-wait; load result untouched
      do_access(32'h0000_0203, 32'h0000_00A5, 1'b1, 1'b1, 0, 32'h0,
                32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, sc, sr);
      check_eq("bs_stall", 32'(sc), 32'd2);
      check_eq("bs_rdata_kept", read_data_m_o, 32'hDEAD_BEEF);
      idle_cycle();

      // Byte load lane 1
      do_access(32'h0000_0301, 32'h0, 1'b0, 1'b1, 0, 32'h1122_8344,
                32'h0000_0300, 4'b0010, 32'h0, sc, sr);
      check_eq("bl_stall", 32'(sc), 32'd3);
      check_eq("bl_rdata", read_data_m_o, 32'h0000_0083);

      // Back-to-back: delayed-grant word store straight after DONE
      do_access(32'h0000_0408, 32'h1234_5678, 1'b1, 1'b0, 5, 32'h0,
                32'h0000_0408, 4'hF, 32'h1234_5678, sc, sr);
      check_eq("ds_stall", 32'(sc), 32'd7);
      check_eq("ds_rdata_kept", read_data_m_o, 32'h0000_0083);
      idle_cycle();

      // Reset while in WAIT_R, then a stale rvalid
      alu_result_m_i = 32'h0000_0104;
      mem_write_m_i  = 1'b0;
      byte_op_m_i    = 1'b0;
      memory_m_i     = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rw_req", {31'd0, dmem_req_o}, 32'd1);
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      #1;
      dmem_gnt_i = 1'b0;
      check_eq("rw_wait_stall", {31'd0, stall_m_o}, 32'd1);
      rst_ni = 1'b0;
      #1;
      check_eq("ar_addr", dmem_addr_o, 32'd0);
      check_eq("ar_be", {28'd0, dmem_be_o}, 32'd0);
      check_eq("ar_rdata", read_data_m_o, 32'd0);
      memory_m_i = 1'b0;
      #1;
      rst_ni        = 1'b1;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      dmem_rvalid_i = 1'b0;
      check_eq("stale_rdata", read_data_m_o, 32'd0);
      check_eq("stale_req", {31'd0, dmem_req_o}, 32'd0);
      memory_m_i = 1'b1;
      #1;
      check_eq("post_rst_idle_stall", {31'd0, stall_m_o}, 32'd1);
      @(negedge clk);
      #1;
      check_eq("post_rst_req", {31'd0, dmem_req_o}, 32'd1);
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      #1;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hCAFE_0001;
      @(negedge clk);
      #1;
      dmem_rvalid_i = 1'b0;
      check_eq("post_rst_rdata", read_data_m_o, 32'hCAFE_0001);
      idle_cycle();

      // Misaligned word load
`ifdef LSU_ALIGN_CHECK_EN
      do_access(32'h0000_0102, 32'h0, 1'b0, 1'b0, 0, 32'h0BAD_F00D,
                32'h0000_0100, 4'hF, 32'h0, sc, sr);
      check_eq("ma_stall", 32'(sc), 32'd1);
      check_eq("ma_no_req", {31'd0, sr}, 32'd0);
      check_eq("ma_flag", {31'd0, misalign_o}, 32'd1);
      check_eq("ma_rdata", read_data_m_o, 32'd0);
      idle_cycle();
      check_eq("ma_flag_clear", {31'd0, misalign_o}, 32'd0);
`else
      do_access(32'h0000_0102, 32'h0, 1'b0, 1'b0, 0, 32'h0BAD_F00D,
                32'h0000_0100, 4'hF, 32'h0, sc, sr);
      check_eq("ma_stall", 32'(sc), 32'd3);
      check_eq("ma_req", {31'd0, sr}, 32'd1);
      check_eq("ma_flag", {31'd0, misalign_o}, 32'd0);
      check_eq("ma_rdata", read_data_m_o, 32'h0BAD_F00D);
      idle_cycle();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage load/store sequencer. It reads the M-stage control and data fields delivered by the execute-to-memory pipeline register, drives a request/grant/response data-memory port, and returns load data to the writeback path. While an access is in flight it holds the pipeline with a combinational stall.

## Interface
Parameters:
- DATA_WIDTH, 32: data and address width. Byte lanes = DATA_WIDTH/8.

Ports:
- clk  in  1  rising-edge clock.
- rst_ni  in  1  asynchronous active-low reset.
- alu_result_m_i  in  DATA_WIDTH  effective byte address.
- write_data_m_i  in  DATA_WIDTH  store data; byte stores use bits [7:0].
- memory_m_i  in  1  current M-stage instruction is a load or store.
- mem_write_m_i  in  1  1 = store, 0 = load; valid only when memory_m_i=1.
- byte_op_m_i  in  1  1 = byte access, 0 = word access.
- stall_m_o  out  1  combinational; freezes the pipeline registers up to and including M.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  DATA_WIDTH  word-aligned address.
- dmem_be_o  out  DATA_WIDTH/8  byte enables.
- dmem_wdata_o  out  DATA_WIDTH  write data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read response valid.
- dmem_rdata_i  in  DATA_WIDTH  read response word.
- read_data_m_o  out  DATA_WIDTH  load result, registered.
- misalign_o  out  1  misaligned-word flag (see Configuration).

## Operation
FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - memory_m_i=1 -> REQ. Address, we, be and wdata are captured into request registers on this edge.
  - Otherwise remain in IDLE.
- REQ:
  - dmem_req_o=1, with all request fields held stable until grant.
  - dmem_gnt_i=1 with a store -> DONE.
  - dmem_gnt_i=1 with a load -> WAIT_R.
  - No grant -> remain in REQ indefinitely.
- WAIT_R:
  - dmem_rvalid_i=1 -> capture the extracted load data into read_data_m_o, then -> DONE.
- DONE: always -> IDLE after one cycle. The pipeline advances on this edge.

Request field formation:
- Address: dmem_addr_o = {addr[DATA_WIDTH-1:2], 2'b00}.
- Word access: be = all ones; wdata = write_data_m_i.
- Byte access: be = 1 << addr[1:0]; wdata = write_data_m_i[7:0] replicated into every lane.

Load data:
- Byte load: lane addr[1:0] of dmem_rdata_i, zero-extended to DATA_WIDTH.
- Word load: dmem_rdata_i unchanged.
- read_data_m_o holds its value until the next load capture. Stores do not modify it.

Ignored inputs and boundary cases:
- dmem_gnt_i outside REQ is ignored.
- dmem_rvalid_i outside WAIT_R is ignored, including a stale response arriving after a reset.
- A grant and an rvalid in the same cycle while in REQ: the grant is honoured and the rvalid is ignored. Responses are always at least one cycle after grant.
- Back-to-back memory instructions: DONE -> IDLE -> REQ. Each instruction is sequenced separately, with no overlap.

## Timing
- stall_m_o = memory_m_i && (state != DONE), combinational.
- Zero-wait memory (grant in the first REQ cycle, rvalid on the next cycle):
  - Load: stall 3 cycles (IDLE, REQ, WAIT_R), then DONE. 4 cycles in the M stage.
  - Store: stall 2 cycles, then DONE. 3 cycles in the M stage.
- read_data_m_o is valid from the DONE cycle onward.
- Reset (rst_ni=0, asynchronous, including mid-transaction):
  - state = IDLE.
  - dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, read_data_m_o and misalign_o all return to 0 immediately.
  - An abandoned outstanding request is not retried.
- All outputs other than stall_m_o are registered.

## Configuration
Macro LSU_ALIGN_CHECK_EN.
- Defined: a word access with addr[1:0] != 0 goes IDLE -> DONE directly.
  - No dmem request is issued.
  - misalign_o = 1 for the DONE cycle only.
  - read_data_m_o is loaded with 0 for a misaligned load.
- Undefined: the low address bits are silently dropped for word accesses and the access proceeds normally. misalign_o is tied to 0. The port is still present.

## Structure
- Package lsu_pkg holds:
  - lsu_state_t, the enum IDLE/REQ/WAIT_R/DONE.
  - BYTE_LANES = DATA_WIDTH/8.
  - LANE_SEL_W = $clog2(BYTE_LANES).
  - A byte-enable function.
- Sub-module byte_lane_unit: combinational write-lane replication, byte-enable generation and load lane extraction/zero-extension. It is instantiated once.

## Test plan
- Word load, addr 0x0000_0104, grant immediate, rvalid next cycle with rdata 0xDEAD_BEEF -> dmem_addr_o 0x104, be 4'hF, stall high 3 cycles, read_data_m_o 0xDEAD_BEEF in DONE.
- Byte store, addr 0x0000_0203, wdata 0x0000_00A5 -> dmem_addr_o 0x200, be 4'b1000, wdata 0xA5A5_A5A5, we 1, stall 2 cycles.
- Byte load, addr 0x...01, rdata 0x1122_8344 -> read_data_m_o 0x0000_0083.
- Grant delayed 5 cycles -> addr, be and wdata stable throughout REQ, stall held, DONE one cycle after grant (store).
- Reset pulse in WAIT_R, then rvalid arrives -> outputs 0 immediately, FSM IDLE, rvalid ignored, read_data_m_o stays 0.
- With LSU_ALIGN_CHECK_EN: word load at 0x...102 -> no dmem_req_o, misalign_o pulses 1 cycle, read_data_m_o 0.
